// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter driving one APB bus (slaves by PADDR[8]).
// Define APB_ARB_TIMEOUT_EN to build the ACCESS-phase PREADY timeout.
module apb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRST,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [8:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ack,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [8:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ack,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [8:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic       PREADY,
    input  logic [7:0] PRDATA,
    input  logic       PSLVERR,
    output logic       grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e     state_q;
    logic       last_grant_q;

    logic       elig0;
    logic       elig1;
    logic       pick_d;
    logic       sel_write;
    logic [8:0] sel_addr;
    logic [7:0] sel_wdata;

    logic       done;
    logic [7:0] done_rdata;
    logic       done_err;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
`endif

    // A requester still showing valid in its own ack cycle is stale.
    always_comb begin
        elig0  = req0_valid & ~req0_ack;
        elig1  = req1_valid & ~req1_ack;
        pick_d = 1'b0;
        if (elig0 && elig1) begin
            pick_d = ~last_grant_q;
        end else if (elig1) begin
            pick_d = 1'b1;
        end
    end

    always_comb begin
        sel_write = pick_d ? req1_write : req0_write;
        sel_addr  = pick_d ? req1_addr  : req0_addr;
        sel_wdata = pick_d ? req1_wdata : req0_wdata;
    end

    always_comb begin
        done       = 1'b0;
        done_rdata = PWRITE ? 8'h00 : PRDATA;
        done_err   = PSLVERR;
        if (state_q == ACCESS) begin
            if (PREADY) begin
                done = 1'b1;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (wait_cnt_q == LIMIT) begin
                done       = 1'b1;
                done_rdata = 8'h00;
                done_err   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant        <= 1'b0;
            busy         <= 1'b0;
            PSEL1        <= 1'b0;
            PSEL2        <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            req0_ack     <= 1'b0;
            req0_rdata   <= '0;
            req0_err     <= 1'b0;
            req1_ack     <= 1'b0;
            req1_rdata   <= '0;
            req1_err     <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (elig0 || elig1) begin
                        state_q      <= SETUP;
                        grant        <= pick_d;
                        last_grant_q <= pick_d;
                        busy         <= 1'b1;
                        PWRITE       <= sel_write;
                        PADDR        <= sel_addr;
                        PWDATA       <= sel_wdata;
                        PSEL1        <= ~sel_addr[8];
                        PSEL2        <= sel_addr[8];
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ACCESS: begin
                    if (done) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        PSEL1   <= 1'b0;
                        PSEL2   <= 1'b0;
                        PENABLE <= 1'b0;
                        if (grant) begin
                            req1_ack   <= 1'b1;
                            req1_rdata <= done_rdata;
                            req1_err   <= done_err;
                        end else begin
                            req0_ack   <= 1'b1;
                            req0_rdata <= done_rdata;
                            req0_err   <= done_err;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_timeout_range: assert property (@(posedge PCLK)
        (TIMEOUT_CYCLES >= 2) && (TIMEOUT_CYCLES <= 255));

    a_psel_onehot: assert property (@(posedge PCLK)
        !(PSEL1 && PSEL2));

    a_ack_excl: assert property (@(posedge PCLK)
        !(req0_ack && req1_ack));

    a_penable_sel: assert property (@(posedge PCLK)
        PENABLE |-> (PSEL1 || PSEL2));

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Self-checking bench for apb_bus_arbiter: vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_apb_bus_arbiter;

    logic       PCLK;
    logic       PRST;
    logic       rv [2];
    logic       rw [2];
    logic [8:0] ra [2];
    logic [7:0] rd [2];
    logic       req0_ack, req1_ack, req0_err, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] PRDATA;
    logic       grant, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit         mem_mode;
    int         s_waits;
    int         wcnt;
    logic [7:0] s_prdata;
    bit         s_slverr;
    logic [7:0] smem [512];
    logic [7:0] refmem [512];

    bit         m_busy, m_own, m_last;
    int         m_gedge, m_done;
    bit   [1:0] m_ack;
    bit         m_req_w;
    logic [8:0] m_req_a;
    logic [7:0] m_req_d;
    logic [7:0] e_rd [2];
    bit         e_err [2];
    bit         e_grant;
    logic [8:0] e_paddr;
    logic [7:0] e_pwdata;
    bit         e_pwrite;
    int         gap [2];

    typedef struct {
        bit         req;
        bit         wr;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] prdata;
        int         waits;
        bit         slverr;
        logic [7:0] exp_rdata;
        bit         exp_err;
        bit         exp_p1;
        bit         exp_p2;
        int         exp_lat;
    } vec_t;
    vec_t vt [5];

    apb_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRST(PRST),
        .req0_valid(rv[0]), .req0_write(rw[0]),
        .req0_addr(ra[0]), .req0_wdata(rd[0]),
        .req0_ack(req0_ack), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(rv[1]), .req1_write(rw[1]),
        .req1_addr(ra[1]), .req1_wdata(rd[1]),
        .req1_ack(req1_ack), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .grant(grant), .busy(busy)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    function automatic bit errf(logic [8:0] a);
        return a[3:0] == 4'hF;
    endfunction

    task automatic check(input string n, input logic [63:0] a,
                         input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic slave_tick();
        if (PENABLE) begin
            PREADY = (wcnt >= s_waits);
            wcnt++;
            if (PREADY && mem_mode && PWRITE) smem[PADDR] = PWDATA;
        end else begin
            PREADY = 1'b0;
            wcnt = 0;
        end
        PRDATA  = mem_mode ? smem[PADDR] : s_prdata;
        PSLVERR = mem_mode ? errf(PADDR) : s_slverr;
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
        slave_tick();
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, req0_ack, req1_ack, req0_rdata, req1_rdata,
                req0_err, req1_err, PSEL1, PSEL2, PENABLE, PWRITE,
                PADDR, PWDATA, grant, busy};
    endfunction

    task automatic run_vec(input vec_t v);
        int  lat;
        bit  got, p1, p2;
        logic [7:0] pw;
        logic ack;
        mem_mode = 0;
        s_prdata = v.prdata;
        s_slverr = v.slverr;
        s_waits  = v.waits;
        rv[v.req] = 1'b1;
        rw[v.req] = v.wr;
        ra[v.req] = v.addr;
        rd[v.req] = v.wdata;
        got = 0; p1 = 0; p2 = 0; pw = 8'h00; lat = 0;
        for (int t = 1; t <= 40 && !got; t++) begin
            tick();
            if (PSEL1) p1 = 1;
            if (PSEL2) p2 = 1;
            if ((PSEL1 || PSEL2) && !PENABLE) pw = PWDATA;
            ack = v.req ? req1_ack : req0_ack;
            if (ack) begin
                got = 1;
                lat = t;
                check("vec_other_ack", v.req ? req0_ack : req1_ack, 0);
                check("vec_rdata", v.req ? req1_rdata : req0_rdata,
                      v.exp_rdata);
                check("vec_err", v.req ? req1_err : req0_err, v.exp_err);
                check("vec_grant", grant, v.req);
            end
        end
        check("vec_acked", got, 1);
        check("vec_latency", lat, v.exp_lat);
        check("vec_psel1", p1, v.exp_p1);
        check("vec_psel2", p2, v.exp_p2);
        if (v.wr) check("vec_pwdata", pw, v.wdata);
        rv[v.req] = 1'b0;
        tick();
        check("vec_idle_after", {busy, PSEL1, PSEL2, PENABLE, req0_ack,
              req1_ack}, 0);
        check("vec_rdata_hold", v.req ? req1_rdata : req0_rdata,
              v.exp_rdata);
        tick();
    endtask

    task automatic model_step();
        int e;
        bit [1:0] pa;
        bit v0, v1;
        e = cyc + 1;
        pa = m_ack;
        m_ack = 2'b00;
        if (m_busy) begin
            if (e == m_done) begin
                m_busy = 0;
                m_ack[m_own] = 1'b1;
                e_err[m_own] = errf(m_req_a);
                if (m_req_w) begin
                    refmem[m_req_a] = m_req_d;
                    e_rd[m_own] = 8'h00;
                end else begin
                    e_rd[m_own] = refmem[m_req_a];
                end
            end
        end else begin
            v0 = rv[0] && !pa[0];
            v1 = rv[1] && !pa[1];
            if (v0 || v1) begin
                m_own    = (v0 && v1) ? !m_last : v1;
                m_last   = m_own;
                m_busy   = 1;
                m_gedge  = e;
                m_req_w  = rw[m_own];
                m_req_a  = ra[m_own];
                m_req_d  = rd[m_own];
                e_grant  = m_own;
                e_pwrite = m_req_w;
                e_paddr  = m_req_a;
                e_pwdata = m_req_d;
                s_waits  = $urandom_range(0, 5);
                m_done   = e + 2 + s_waits;
            end
        end
    endtask

    task automatic compare_model();
        check("r_ack0", req0_ack, m_ack[0]);
        check("r_ack1", req1_ack, m_ack[1]);
        check("r_rdata0", req0_rdata, e_rd[0]);
        check("r_rdata1", req1_rdata, e_rd[1]);
        check("r_err0", req0_err, e_err[0]);
        check("r_err1", req1_err, e_err[1]);
        check("r_grant", grant, e_grant);
        check("r_busy", busy, m_busy);
        check("r_psel1", PSEL1, m_busy && !e_paddr[8]);
        check("r_psel2", PSEL2, m_busy && e_paddr[8]);
        check("r_penable", PENABLE, m_busy && (cyc != m_gedge));
        check("r_paddr", PADDR, e_paddr);
        check("r_pwdata", PWDATA, e_pwdata);
        check("r_pwrite", PWRITE, e_pwrite);
    endtask

    task automatic new_req(input int r);
        rv[r] = 1'b1;
        rw[r] = 1'($urandom_range(0, 1));
        ra[r] = {1'($urandom_range(0, 1)), 4'h0, 4'($urandom_range(0, 15))};
        rd[r] = 8'($urandom);
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            if (m_ack[r]) begin
                rv[r] = 1'b0;
                gap[r] = $urandom_range(0, 2);
            end
            if (!rv[r]) begin
                if (gap[r] == 0) new_req(r);
                else gap[r]--;
            end
        end
    endtask

    initial begin
        bit hit;
        vt[0] = '{0, 1, 9'h005, 8'hA5, 8'h77, 0, 0, 8'h00, 0, 1, 0, 3};
        vt[1] = '{1, 0, 9'h10C, 8'h00, 8'h3C, 0, 0, 8'h3C, 0, 0, 1, 3};
        vt[2] = '{0, 0, 9'h0FF, 8'h00, 8'h81, 4, 1, 8'h81, 1, 1, 0, 7};
        vt[3] = '{1, 1, 9'h1AA, 8'h5A, 8'hEE, 1, 0, 8'h00, 0, 0, 1, 4};
        vt[4] = '{0, 0, 9'h100, 8'h00, 8'hE7, 2, 0, 8'hE7, 0, 0, 1, 5};

        PRST = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rv[r] = 0; rw[r] = 0; ra[r] = '0; rd[r] = '0;
        end
        PREADY = 0; PRDATA = '0; PSLVERR = 0;
        mem_mode = 0; s_waits = 0; s_prdata = 8'h11; s_slverr = 0; wcnt = 0;
        tick();
        tick();
        check("reset_outs", all_outs(), 0);

        // Contention straight out of reset: req0 first, then alternate.
        PRST = 1'b0;
        rv[0] = 1; ra[0] = 9'h004;
        rv[1] = 1; ra[1] = 9'h104;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("cont_ack0", req0_ack, (t % 6) == 3);
            check("cont_ack1", req1_ack, (t % 6) == 0);
            if ((t % 3) == 1) check("cont_grant", grant, (t / 3) % 2);
        end
        rv[0] = 0; rv[1] = 0;
        tick();
        tick();

        foreach (vt[i]) run_vec(vt[i]);

        // Reset while a transfer sits in ACCESS.
        mem_mode = 0; s_waits = 10; s_prdata = 8'h99;
        rv[0] = 1; rw[0] = 0; ra[0] = 9'h033;
        hit = 0;
        for (int t = 0; t < 10 && !hit; t++) begin
            tick();
            if (PENABLE) hit = 1;
        end
        check("rst_reach_access", hit, 1);
        PRST = 1'b1;
        rv[0] = 0;
        tick();
        check("rst_mid_outs", all_outs(), 0);
        PRST = 1'b0;
        s_waits = 0;
        rv[0] = 1; rw[0] = 0; ra[0] = 9'h010;
        rv[1] = 1; rw[1] = 0; ra[1] = 9'h110;
        tick();
        check("rst_first_grant", grant, 0);
        check("rst_first_psel", {PSEL1, PSEL2}, 2'b10);
        tick();
        tick();
        check("rst_ack0", {req0_ack, req1_ack}, 2'b10);
        rv[0] = 0;
        tick();
        check("rst_second_grant", grant, 1);
        check("rst_second_psel", {PSEL1, PSEL2}, 2'b01);
        tick();
        tick();
        check("rst_ack1", {req0_ack, req1_ack}, 2'b01);
        rv[1] = 0;
        tick();
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        mem_mode = 0; s_waits = 255; s_prdata = 8'hCC; s_slverr = 0;
        rv[0] = 1; rw[0] = 0; ra[0] = 9'h020;
        hit = 0;
        for (int t = 1; t <= 60 && !hit; t++) begin
            tick();
            if (req0_ack) begin
                hit = 1;
                check("to_latency", t, 18);
                check("to_err", req0_err, 1);
                check("to_rdata", req0_rdata, 8'h00);
            end
        end
        check("to_acked", hit, 1);
        rv[0] = 0;
        tick();
        check("to_idle", {busy, PSEL1, PSEL2, PENABLE}, 0);
        tick();
`endif

        // Randomized traffic against the transaction-level model.
        PRST = 1'b1;
        rv[0] = 0; rv[1] = 0;
        tick();
        tick();
        PRST = 1'b0;
        mem_mode = 1;
        for (int i = 0; i < 512; i++) begin
            smem[i]   = 8'(i * 7 + 3);
            refmem[i] = 8'(i * 7 + 3);
        end
        m_busy = 0; m_own = 0; m_last = 1; m_ack = 0;
        m_gedge = -10; m_done = -10;
        e_rd[0] = 0; e_rd[1] = 0; e_err[0] = 0; e_err[1] = 0;
        e_grant = 0; e_paddr = 0; e_pwdata = 0; e_pwrite = 0;
        gap[0] = 0; gap[1] = 0;
        slave_tick();
        for (int i = 0; i < 600; i++) begin
            model_step();
            tick();
            compare_model();
            drive_reqs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
